// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, drives the instruction-memory
// word index and captures the returned word into the IF/ID register.
// Handles load-use stalls, branch/jump redirects and out-of-range fetches.
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH = 21,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      imem_pc_o,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH    = 32'(MEM_DEPTH);
    localparam logic [31:0] PC_RESET = 32'(RESET_PC);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      ifpc_q, ifpc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_in_range;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned 32-bit range test; the memory is never addressed past its end.
    assign pc_in_range = (pc_q < DEPTH);
    assign imem_pc_o   = pc_in_range ? pc_q : 32'd0;

    // Next-state logic: redirect beats stall, stall beats range check, then fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_BOOT: begin
                // One dead cycle with no capture; stall has no meaning yet.
                state_d = S_RUN;
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
            end
            S_RUN: begin
                if (redirect_i) begin
                    // Squash whatever is in IF/ID but leave its payload alone.
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                end else if (stall_i) begin
                    // Everything holds, including the valid bit.
                end else if (!pc_in_range) begin
                    valid_d = 1'b0;
                    state_d = S_HALT;
                end else begin
                    instr_d = imem_instr_i;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd1;
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            S_HALT: begin
                // Only a redirect gets us out; an out-of-range target comes
                // straight back here via the RUN range check.
                valid_d = 1'b0;
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
                valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == S_HALT);
    end

    // State, PC, IF/ID and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BOOT;
            pc_q     <= PC_RESET;
            instr_q  <= 32'd0;
            ifpc_q   <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ifid_instr_o  = instr_q;
    assign ifid_pc_o     = ifpc_q;
    assign ifid_valid_o  = valid_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 16-bit-counter instance and a
// 4-bit-counter instance share one stimulus stream.
module tb_fetch_sequencer;

    localparam logic [31:0] TAG = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] imem_pc, imem_instr, ifid_instr, ifid_pc;
    logic        ifid_valid, halted;
    logic [15:0] fcount;

    logic [31:0] imem_pc4, imem_instr4, ifid_instr4, ifid_pc4;
    logic        ifid_valid4, halted4;
    logic [3:0]  fcount4;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    // Instruction memory: word i holds TAG|i so instr and pc are distinguishable.
    assign imem_instr  = TAG | imem_pc;
    assign imem_instr4 = TAG | imem_pc4;

    fetch_sequencer #(.MEM_DEPTH(21), .RESET_PC(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_pc_o(imem_pc), .imem_instr_i(imem_instr),
        .ifid_instr_o(ifid_instr), .ifid_pc_o(ifid_pc), .ifid_valid_o(ifid_valid),
        .halted_o(halted), .fetch_count_o(fcount)
    );

    fetch_sequencer #(.MEM_DEPTH(21), .RESET_PC(0), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_pc_o(imem_pc4), .imem_instr_i(imem_instr4),
        .ifid_instr_o(ifid_instr4), .ifid_pc_o(ifid_pc4), .ifid_valid_o(ifid_valid4),
        .halted_o(halted4), .fetch_count_o(fcount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] p);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({tag, ".pc"}, ifid_pc, p);
        if (v) chk({tag, ".instr"}, ifid_instr, TAG | p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        #3;
        chk("rst.valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst.pc", ifid_pc, 32'd0);
        chk("rst.instr", ifid_instr, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.count", {16'd0, fcount}, 32'd0);
        chk("rst.imem_pc", imem_pc, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // BOOT bubble, PC not advanced
        tick();
        chk("boot.valid", {31'd0, ifid_valid}, 32'd0);
        chk("boot.imem_pc", imem_pc, 32'd0);

        // Free run through the whole memory
        for (int i = 0; i < 21; i++) begin
            tick();
            chk_if("run", 1'b1, i);
            chk("run.count", {16'd0, fcount}, i + 1);
            chk("run.imem_pc", imem_pc, (i + 1 < 21) ? i + 1 : 0);
        end
        tick();
        chk("end.valid", {31'd0, ifid_valid}, 32'd0);
        chk("end.halted", {31'd0, halted}, 32'd1);
        chk("end.count", {16'd0, fcount}, 32'd21);
        chk("end.count4", {28'd0, fcount4}, 32'd15);
        stall = 1'b1;
        tick();
        chk("halt_stall.halted", {31'd0, halted}, 32'd1);
        stall = 1'b0;

        // Leave HALT by redirect to 4
        redirect = 1'b1; redirect_pc = 32'd4;
        tick();
        redirect = 1'b0;
        chk("unhalt.halted", {31'd0, halted}, 32'd0);
        chk("unhalt.valid", {31'd0, ifid_valid}, 32'd0);
        chk("unhalt.imem_pc", imem_pc, 32'd4);
        tick(); chk_if("unhalt4", 1'b1, 4);
        tick(); chk_if("unhalt5", 1'b1, 5);
        chk("pre_stall.count", {16'd0, fcount}, 32'd23);

        // Three-cycle stall while IF/ID holds PC 5
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_if("stall", 1'b1, 5);
            chk("stall.count", {16'd0, fcount}, 32'd23);
            chk("stall.imem_pc", imem_pc, 32'd6);
        end
        stall = 1'b0;
        tick(); chk_if("resume6", 1'b1, 6);
        chk("resume.count", {16'd0, fcount}, 32'd24);
        tick(); chk_if("resume7", 1'b1, 7);

        // Redirect and stall together, target 2: redirect wins
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'd2;
        tick();
        redirect = 1'b0; stall = 1'b0;
        chk_if("redir_bubble", 1'b0, 7);
        chk("redir.count", {16'd0, fcount}, 32'd25);
        tick(); chk_if("redir2", 1'b1, 2);
        tick(); chk_if("redir3", 1'b1, 3);
        chk("redir3.count", {16'd0, fcount}, 32'd27);

        // Redirect out of range from RUN
        redirect = 1'b1; redirect_pc = 32'd30;
        tick();
        redirect = 1'b0;
        chk("oor.valid", {31'd0, ifid_valid}, 32'd0);
        chk("oor.halted", {31'd0, halted}, 32'd0);
        chk("oor.imem_pc", imem_pc, 32'd0);
        tick();
        chk("oor2.halted", {31'd0, halted}, 32'd1);
        chk("oor2.valid", {31'd0, ifid_valid}, 32'd0);
        chk("oor2.count", {16'd0, fcount}, 32'd27);

        // Async reset while PC 9 is being fetched
        redirect = 1'b1; redirect_pc = 32'd9;
        tick();
        redirect = 1'b0;
        chk("pc9.imem_pc", imem_pc, 32'd9);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst.pc", ifid_pc, 32'd0);
        chk("arst.instr", ifid_instr, 32'd0);
        chk("arst.halted", {31'd0, halted}, 32'd0);
        chk("arst.count", {16'd0, fcount}, 32'd0);
        chk("arst.imem_pc", imem_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("reboot.valid", {31'd0, ifid_valid}, 32'd0);
        tick();
        chk_if("reboot0", 1'b1, 0);
        chk("reboot.count", {16'd0, fcount}, 32'd1);

        // Looping redirects to push the 4-bit counter past its limit
        exp_cnt = 1;
        for (int k = 0; k < 20; k++) begin
            redirect    = (k % 6 == 5);
            redirect_pc = 32'd0;
            tick();
            if (k % 6 != 5) exp_cnt++;
            chk("loop.count", {16'd0, fcount}, exp_cnt);
            chk("loop.count4", {28'd0, fcount4}, (exp_cnt > 15) ? 15 : exp_cnt);
        end
        redirect = 1'b0;
        chk("sat.count4", {28'd0, fcount4}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the pipelined core. It owns the program counter and drives the word index into the combinational-read instruction memory. It captures the returned word into the IF/ID pipeline register, and handles pipeline stalls, branch/jump redirects and out-of-range fetches. It sits between the hazard/branch logic in ID/EX and the instruction memory.

## Interface
Parameters:
- `MEM_DEPTH`, default 21: number of valid instruction words; legal indices are 0..MEM_DEPTH-1.
- `RESET_PC`, default 0: word index loaded into the PC on reset.
- `CNT_W`, default 16: width of the fetch counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hold the PC and IF/ID contents this cycle (load-use hazard).
- `redirect_i`  in  1  branch/jump taken; load `redirect_pc_i` and squash IF/ID.
- `redirect_pc_i`  in  32  word-index redirect target.
- `imem_pc_o`  out  32  word index to instruction memory; combinational from the PC register.
- `imem_instr_i`  in  32  instruction word from memory; valid in the same cycle as `imem_pc_o`.
- `ifid_instr_o`  out  32  IF/ID instruction register.
- `ifid_pc_o`  out  32  IF/ID PC register; holds the index the instruction was fetched from.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `halted_o`  out  1  sequencer is in HALT.
- `fetch_count_o`  out  CNT_W  number of accepted fetches; saturates.

## Operation
The state register has three values: BOOT, RUN and HALT.
- `halted_o` is 1 only in HALT.

Reset (async, `rst_n`=0):
- state=BOOT, PC=RESET_PC.
- `ifid_instr_o`=0, `ifid_pc_o`=0, `ifid_valid_o`=0.
- `halted_o`=0, `fetch_count_o`=0.

BOOT lasts exactly one cycle and performs no capture; `ifid_valid_o` stays 0.
- Next state is RUN.
- `stall_i` is ignored in BOOT.
- If `redirect_i`=1 in BOOT, PC is loaded with `redirect_pc_i`.

RUN: each cycle, actions are evaluated in priority order.
1. `redirect_i`=1: PC<=`redirect_pc_i`, `ifid_valid_o`<=0, IF/ID instr/pc unchanged, no count. Redirect beats stall.
2. `stall_i`=1: PC, `ifid_instr_o`, `ifid_pc_o` and `ifid_valid_o` all hold, no count.
3. PC >= MEM_DEPTH: no fetch, `ifid_valid_o`<=0, state<=HALT.
4. Otherwise fetch:
   - `ifid_instr_o`<=`imem_instr_i`, `ifid_pc_o`<=PC, `ifid_valid_o`<=1.
   - PC<=PC+1, with modulo-2^32 wrap.
   - `fetch_count_o`<=`fetch_count_o`+1, saturating at 2^CNT_W-1.

HALT:
- `ifid_valid_o`=0 and PC holds.
- `stall_i` is ignored.
- `redirect_i`=1: PC<=`redirect_pc_i` and state<=RUN. An out-of-range target re-enters HALT through rule 3 on the next cycle.

Output and range rules:
- `imem_pc_o` = PC when PC < MEM_DEPTH, else 0. The memory is never indexed out of range.
- Out-of-range comparison is an unsigned 32-bit comparison.

## Timing
- Fetch latency is one cycle. A PC presented in cycle k appears on `ifid_*` after the rising edge ending cycle k.
- Sustained throughput is one instruction per cycle with no bubbles in RUN.
- Redirect penalty:
  - Redirect in cycle k gives `ifid_valid_o`=0 in cycle k+1.
  - The target instruction is valid in cycle k+2.
- Stall held for n cycles freezes all outputs for n cycles. The fetch resumes with the same PC on the first unstalled cycle.
- After `rst_n` deasserts, the first valid IF/ID appears at the end of the second rising edge (BOOT, then first fetch).
- Reset asserted mid-operation clears everything immediately (asynchronous), regardless of state or pending stall/redirect.
- All outputs except `imem_pc_o` are registered. `imem_pc_o` is a combinational function of the PC register only; there is no path from the inputs.

## Test plan
- Reset, then free-run with memory words 0..20 = index values: `ifid_valid_o`=0 for 1 cycle, then `ifid_pc_o`/`ifid_instr_o` = 0,1,2,…,20 on consecutive cycles. Next cycle `ifid_valid_o`=0 and `halted_o`=1; `fetch_count_o`=21.
- Stall asserted for 3 cycles while IF/ID holds PC 5: outputs frozen at 5 for 3 cycles, then PC 6 follows with no gap; count unaffected during the stall.
- Redirect and stall asserted together at PC 7 with target 2: `ifid_valid_o`=0 one cycle, then `ifid_pc_o`=2, 3, …
- From HALT, redirect to 4: `halted_o` drops the next cycle, then `ifid_pc_o`=4 valid. Redirect to 30 from RUN: HALT after one bubble cycle, and `imem_pc_o` reads 0 while PC=30.
- With `CNT_W`=4, run more than 16 fetches using looping redirects: `fetch_count_o` saturates at 15.
- Assert `rst_n`=0 asynchronously mid-fetch at PC 9: all outputs clear before the next edge, and the PC restarts at `RESET_PC` with the BOOT bubble.
